// File: rtl/genius_engine.sv
// Genius/Simon game core: LFSR sequence, timed playback,
// edge-detected player input with timeout, win/lose flags.
module genius_engine #(
  parameter int N_BTN          = 4,
  parameter int MAX_LEVEL      = 16,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W = $clog2(N_BTN),
  localparam int LVL_W = $clog2(MAX_LEVEL + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [N_BTN-1:0] btn,
  output logic             show_valid,
  output logic [IDX_W-1:0] show_idx,
  output logic             awaiting_input,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] step,
  output logic             win,
  output logic             lose
);

  localparam int AW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int SG = (SHOW_CYCLES > GAP_CYCLES) ?
                      SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX = (SG > TIMEOUT_CYCLES) ? SG : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, APPEND, SHOW_ON, SHOW_GAP, INPUT, WIN, LOSE
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] mem [MAX_LEVEL];
  logic [15:0]      lfsr_q, lfsr_d;
  logic             start_q;
  logic [N_BTN-1:0] btn_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] step_q, step_d;
  logic             mem_we;

  logic             start_edge;
  logic [N_BTN-1:0] press;
  logic [IDX_W-1:0] press_idx;
  logic [IDX_W-1:0] sym;
  logic [IDX_W-1:0] cur;
  logic [15:0]      lfsr_adv;
  logic             last;

  assign start_edge = start & ~start_q;
  assign press      = btn & ~btn_q;
  assign sym        = IDX_W'(lfsr_q % 16'(N_BTN));
  assign cur        = mem[step_q[AW-1:0]];
  assign last       = step_q == level_q - LVL_W'(1);
  assign lfsr_adv   = {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    press_idx = '0;
    for (int i = 0; i < N_BTN; i++)
      if (press[i]) press_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    timer_d = timer_q;
    level_d = level_q;
    step_d  = step_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start_edge) begin
          lfsr_d  = (seed == 16'd0) ? 16'hACE1 : seed;
          level_d = '0;
          step_d  = '0;
          timer_d = '0;
          state_d = APPEND;
        end
      end
      APPEND: begin
        mem_we  = 1'b1;
        lfsr_d  = lfsr_adv;
        level_d = level_q + LVL_W'(1);
        step_d  = '0;
        timer_d = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer_q == TW'(SHOW_CYCLES - 1)) begin
          timer_d = '0;
          state_d = SHOW_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SHOW_GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          if (last) begin
            step_d  = '0;
            state_d = INPUT;
          end else begin
            step_d  = step_q + LVL_W'(1);
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      INPUT: begin
        if (press == '0) begin
          if (timer_q == TW'(TIMEOUT_CYCLES - 1))
            state_d = LOSE;
          else
            timer_d = timer_q + TW'(1);
        end else if ($onehot(press) && press_idx == cur) begin
          timer_d = '0;
          if (last)
            state_d = (level_q == LVL_W'(MAX_LEVEL)) ? WIN : APPEND;
          else
            step_d = step_q + LVL_W'(1);
        end else begin
          state_d = LOSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // start_q resets high so a start held through reset is not an edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      start_q <= 1'b1;
      btn_q   <= '0;
      timer_q <= '0;
      level_q <= '0;
      step_q  <= '0;
      for (int i = 0; i < MAX_LEVEL; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start;
      btn_q   <= btn;
      timer_q <= timer_d;
      level_q <= level_d;
      step_q  <= step_d;
      if (mem_we) mem[level_q[AW-1:0]] <= sym;
    end
  end

  assign show_valid     = state_q == SHOW_ON;
  assign show_idx       = show_valid ? cur : '0;
  assign awaiting_input = state_q == INPUT;
  assign level          = level_q;
  assign step           = step_q;
  assign win            = state_q == WIN;
  assign lose           = state_q == LOSE;

endmodule

// File: tb/tb_genius_engine.sv
// Randomised bench for genius_engine against a
// sequence/timeline reference model.
module tb_genius_engine;

  localparam int N  = 4;
  localparam int ML = 16;
  localparam int SC = 4;
  localparam int GC = 2;
  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b1;
  logic [15:0] seed  = '0;
  logic [3:0]  btn   = '0;
  logic        show_valid;
  logic [1:0]  show_idx;
  logic        awaiting_input;
  logic [4:0]  level;
  logic [4:0]  step;
  logic        win;
  logic        lose;

  int errors = 0;
  int checks = 0;
  int seq [ML];

  genius_engine u_dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .btn            (btn),
    .show_valid     (show_valid),
    .show_idx       (show_idx),
    .awaiting_input (awaiting_input),
    .level          (level),
    .step           (step),
    .win            (win),
    .lose           (lose)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Reference sequence: successive LFSR states taken mod N
  task automatic build_seq(input logic [15:0] s);
    logic [15:0] l;
    l = (s == 16'd0) ? 16'hACE1 : s;
    for (int k = 0; k < ML; k++) begin
      seq[k] = int'(l) % N;
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  task automatic start_game(input logic [15:0] s);
    build_seq(s);
    seed  = s;
    start = 1'b1;
    tick();
    check("append_show", show_valid, 0);
    check("append_lose", lose, 0);
    check("append_win", win, 0);
    start = 1'b0;
    seed  = 16'($urandom);
    tick();
  endtask

  task automatic show_phase(input int L, input bit poke,
                            input bit hold);
    check("show_level", level, L);
    for (int k = 0; k < L; k++) begin
      for (int c = 0; c < SC + GC; c++) begin
        check("show_valid", show_valid, (c < SC) ? 1 : 0);
        check("show_idx", show_idx, (c < SC) ? seq[k] : 0);
        check("show_step", step, k);
        check("show_await", awaiting_input, 0);
        if (poke && k == 0 && c == 1) start = 1'b1;
        if (poke && k == 0 && c == 2) start = 1'b0;
        if (hold && k == L - 1 && c == SC + GC - 1)
          btn = 4'(1 << seq[0]);
        tick();
      end
    end
    check("input_await", awaiting_input, 1);
    check("input_step", step, 0);
    check("input_level", level, L);
    if (hold) begin
      tick();
      check("hold_await", awaiting_input, 1);
      check("hold_step", step, 0);
      check("hold_lose", lose, 0);
      btn = '0;
      tick();
    end
  endtask

  task automatic answer(input int L);
    for (int k = 0; k < L; k++) begin
      repeat ($urandom_range(1, 8)) tick();
      btn = 4'(1 << seq[k]);
      tick();
      btn = '0;
      check("ans_lose", lose, 0);
      if (k < L - 1) begin
        check("ans_await", awaiting_input, 1);
        check("ans_step", step, k + 1);
      end else if (L == ML) begin
        check("win_flag", win, 1);
        check("win_level", level, ML);
      end else begin
        check("ans_append", awaiting_input, 0);
        check("ans_level", level, L);
        tick();
      end
    end
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_sv"}, show_valid, 0);
    check({tag, "_idx"}, show_idx, 0);
    check({tag, "_aw"}, awaiting_input, 0);
    check({tag, "_lvl"}, level, 0);
    check({tag, "_stp"}, step, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
  endtask

  initial begin
    int w;
    #1 outs_zero("rst");
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    outs_zero("held_start");
    start = 1'b0;
    tick();

    // seed 1: first symbol is 1
    start_game(16'h0001);
    check("seed1_idx", show_idx, 1);
    show_phase(1, 0, 0);
    answer(1);
    show_phase(2, 1, 0);
    answer(2);
    show_phase(3, 0, 1);
    w = (seq[0] + 1 + $urandom_range(0, 2)) % N;
    btn = 4'(1 << w);
    tick();
    btn = '0;
    check("wrong_lose", lose, 1);
    check("wrong_await", awaiting_input, 0);
    check("wrong_level", level, 3);
    repeat (5) tick();
    btn = 4'hF;
    tick();
    btn = '0;
    check("lose_held", lose, 1);
    check("lose_level", level, 3);
    check("lose_step", step, 0);

    // restart, timer reset by press, then timeout
    start_game(16'($urandom));
    show_phase(1, 0, 0);
    repeat (TO - 2) tick();
    check("to_await", awaiting_input, 1);
    btn = 4'(1 << seq[0]);
    tick();
    btn = '0;
    check("to_press_lose", lose, 0);
    check("to_press_aw", awaiting_input, 0);
    tick();
    show_phase(2, 0, 0);
    repeat (TO - 1) tick();
    check("to_pre_aw", awaiting_input, 1);
    check("to_pre_lose", lose, 0);
    tick();
    check("to_lose", lose, 1);
    check("to_level", level, 2);

    // seed 0 behaves as 16'hACE1, then a two-button press
    start_game(16'h0000);
    show_phase(1, 0, 0);
    answer(1);
    show_phase(2, 0, 0);
    btn = 4'b0011;
    tick();
    btn = '0;
    check("multi_lose", lose, 1);

    // full game to win
    start_game(16'($urandom_range(1, 65535)));
    for (int L = 1; L <= ML; L++) begin
      show_phase(L, L == 2, L == 4);
      answer(L);
    end
    repeat (4) tick();
    check("win_held", win, 1);
    check("win_lvl_held", level, ML);
    check("win_step", step, ML - 1);
    check("win_lose", lose, 0);

    // asynchronous reset in the middle of a show
    start_game(16'($urandom));
    show_phase(1, 0, 0);
    answer(1);
    tick();
    check("pre_rst_sv", show_valid, 1);
    #2 reset = 1'b0;
    #1 outs_zero("async");
    tick();
    reset = 1'b1;
    repeat (3) tick();
    outs_zero("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
